// File: rtl/rv_isa_pkg.sv
// ---------------------------------------------------------------------------
// rv_isa_pkg
// Purpose : Shared RV32I/M ALU encodings. The instruction encoder and the ALU
//           decoder both import this package so they agree on every field.
// Contents: op_e operation enum (matches the encoder's in_op numbering),
//           major opcodes, funct3/funct7 constants and small lookup helpers.
// ---------------------------------------------------------------------------
package rv_isa_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SRA  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SLL  = 4'd10
  } op_e;

  localparam logic [3:0] OP_LAST = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3 for an operation; unknown ops map to the ADD group (they are
  // flagged illegal separately and never enqueued).
  function automatic logic [2:0] funct3_of(input logic [3:0] op);
    logic [2:0] f3;
    case (op)
      OP_ADD, OP_SUB, OP_MUL: f3 = F3_ADD;
      OP_SLL:                 f3 = F3_SLL;
      OP_SLT:                 f3 = F3_SLT;
      OP_SLTU:                f3 = F3_SLTU;
      OP_XOR:                 f3 = F3_XOR;
      OP_SRL, OP_SRA:         f3 = F3_SR;
      OP_OR:                  f3 = F3_OR;
      OP_AND:                 f3 = F3_AND;
      default:                f3 = F3_ADD;
    endcase
    return f3;
  endfunction

  // funct7 for an operation; also valid for immediate shifts (SRAI uses ALT).
  function automatic logic [6:0] funct7_of(input logic [3:0] op);
    logic [6:0] f7;
    case (op)
      OP_SUB, OP_SRA: f7 = F7_ALT;
      OP_MUL:         f7 = F7_MULDIV;
      default:        f7 = F7_BASE;
    endcase
    return f7;
  endfunction

  // True for the three shift operations (immediate form carries shamt).
  function automatic logic op_is_shift(input logic [3:0] op);
    logic sh;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: sh = 1'b1;
      default:                sh = 1'b0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/rv_sync_fifo.sv
// ---------------------------------------------------------------------------
// rv_sync_fifo
// Purpose : Small synchronous FIFO with show-ahead output (head word is
//           visible on data_o whenever valid_o is high, zero when empty).
// Ports   : clk, rst (sync, active-low), push_i/data_i write side,
//           pop_i read side, data_o/valid_o head word, count_o occupancy.
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module rv_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Guarded push/pop and next-state for pointers and occupancy.
  always_comb begin
    do_pop_s  = pop_i && (count_q != '0);
    // A push into a full FIFO is only taken when a pop frees a slot.
    do_push_s = push_i && ((count_q != FULL_CNT) || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + CW'(1);
    end else if (!do_push_s && do_pop_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Pointer and occupancy registers; reset discards all contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; stale entries are harmless because data_o is masked.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/rv_instr_encoder.sv
// ---------------------------------------------------------------------------
// rv_instr_encoder
// Purpose : Builds RV32I/M R-type and I-type ALU instruction words from
//           decoded fields, drops illegal requests (with a one-cycle error
//           pulse) and streams legal words out through a small FIFO.
// Ports   : clk, rst (sync, active-low)
//           in_valid/in_ready + in_op, in_imm_sel, in_rd, in_rs1, in_rs2,
//           in_imm  : request side
//           out_valid/out_ready + out_code : encoded word stream
//           err_illegal : pulse, previous accepted request was illegal
//           issued_cnt  : number of words popped, wraps
// ---------------------------------------------------------------------------
module rv_instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic             in_imm_sel,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [11:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_code,
  output logic             err_illegal,
  output logic [CNT_W-1:0] issued_cnt
);

  import rv_isa_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [2:0]       f3_s;
  logic [6:0]       f7_s;
  logic             is_shift_s;
  logic             illegal_s;
  logic [31:0]      code_s;
  logic             accept_s, push_s, pop_s;
  logic [CW-1:0]    fifo_count_s;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Field lookup, legality check and word assembly for the current request.
  always_comb begin
    f3_s       = funct3_of(in_op);
    f7_s       = funct7_of(in_op);
    is_shift_s = op_is_shift(in_op);
    illegal_s  = 1'b0;
    if (in_op > OP_LAST) begin
      illegal_s = 1'b1;
    end else if (in_imm_sel && ((in_op == OP_SUB) || (in_op == OP_MUL))) begin
      illegal_s = 1'b1;
    end else if (in_imm_sel && is_shift_s && (in_imm[11:5] != 7'd0)) begin
      // Immediate shifts only have a 5-bit shamt; upper bits must be zero.
      illegal_s = 1'b1;
    end else begin
      illegal_s = 1'b0;
    end
    code_s = 32'd0;
    if (!in_imm_sel) begin
      code_s = {f7_s, in_rs2, in_rs1, f3_s, in_rd, OPC_OP};
    end else if (is_shift_s) begin
      code_s = {f7_s, in_imm[4:0], in_rs1, f3_s, in_rd, OPC_OP_IMM};
    end else begin
      code_s = {in_imm, in_rs1, f3_s, in_rd, OPC_OP_IMM};
    end
  end

  // Handshake: ready depends only on registered occupancy and the pop side.
  assign in_ready = (fifo_count_s < CW'(DEPTH)) || (out_valid && out_ready);
  assign accept_s = in_valid && in_ready;
  assign push_s   = accept_s && !illegal_s;
  assign pop_s    = out_valid && out_ready;

  rv_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .data_i  (code_s),
    .pop_i   (pop_s),
    .data_o  (out_code),
    .valid_o (out_valid),
    .count_o (fifo_count_s)
  );

  // Next state for the error pulse and the issued-word counter.
  always_comb begin
    err_d = accept_s && illegal_s;
    cnt_d = cnt_q;
    if (pop_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Error pulse and issued counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_illegal = err_q;
  assign issued_cnt  = cnt_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder with hand-computed instruction words.
module tb_rv_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic        in_imm_sel;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [11:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_code;
  logic        err_illegal;
  logic [15:0] issued_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_issued = 0;

  always #5 clk = ~clk;

  rv_instr_encoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_imm_sel  (in_imm_sel),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .err_illegal (err_illegal),
    .issued_cnt  (issued_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] op, input logic sel, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    in_op = op; in_imm_sel = sel; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Push one legal request into an empty FIFO, check the word, then pop it.
  task automatic push_pop(input string tag, input logic [31:0] exp);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_code"}, out_code, exp);
    check_eq({tag, "_err"}, 32'(err_illegal), 32'd0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    exp_issued++;
    check_eq({tag, "_empty"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_cnt"}, 32'(issued_cnt), 32'(exp_issued));
  endtask

  // Illegal request: accepted, nothing queued, one-cycle error pulse.
  task automatic illegal_req(input string tag);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    check_eq({tag, "_err1"}, 32'(err_illegal), 32'd1);
    check_eq({tag, "_novld"}, 32'(out_valid), 32'd0);
    cyc();
    check_eq({tag, "_err0"}, 32'(err_illegal), 32'd0);
    check_eq({tag, "_novld2"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int pops;
    int guard;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);
    cyc(); cyc();
    check_eq("rst_vld", 32'(out_valid), 32'd0);
    check_eq("rst_code", out_code, 32'd0);
    check_eq("rst_err", 32'(err_illegal), 32'd0);
    check_eq("rst_cnt", 32'(issued_cnt), 32'd0);
    rst = 1'b1;
    cyc();

    // Basic encodes
    set_req(4'd0, 1'b0, 5'd0, 5'd2, 5'd4, 12'd0);  push_pop("add",  32'h00410033);
    set_req(4'd1, 1'b0, 5'd0, 5'd2, 5'd4, 12'd0);  push_pop("sub",  32'h40410033);
    set_req(4'd2, 1'b0, 5'd0, 5'd2, 5'd4, 12'd0);  push_pop("mul",  32'h02410033);
    set_req(4'd0, 1'b1, 5'd0, 5'd7, 5'd0, 12'd3);  push_pop("addi", 32'h00338013);
    set_req(4'd8, 1'b1, 5'd0, 5'd26, 5'd0, 12'd1); push_pop("srai", 32'h401D5013);
    set_req(4'd10, 1'b1, 5'd0, 5'd3, 5'd0, 12'd1); push_pop("slli", 32'h00119013);

    // Illegal requests
    set_req(4'd1, 1'b1, 5'd1, 5'd2, 5'd3, 12'd5);      illegal_req("ill_subi");
    set_req(4'd12, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);     illegal_req("ill_op12");
    set_req(4'd9, 1'b1, 5'd1, 5'd2, 5'd0, 12'h021);    illegal_req("ill_shamt");
    check_eq("ill_cnt", 32'(issued_cnt), 32'(exp_issued));

    // Backpressure: three pushes with out_ready low
    out_ready = 1'b0;
    set_req(4'd0, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0); in_valid = 1'b1;   // w1
    cyc();
    check_eq("bp_w1", out_code, 32'h003100B3);
    check_eq("bp_rdy1", 32'(in_ready), 32'd1);
    set_req(4'd5, 1'b0, 5'd5, 5'd6, 5'd7, 12'd0);                    // w2
    cyc();
    check_eq("bp_full_rdy", 32'(in_ready), 32'd0);
    check_eq("bp_hold1", out_code, 32'h003100B3);
    set_req(4'd4, 1'b1, 5'd8, 5'd9, 5'd0, 12'h0FF);                  // w3
    cyc();
    check_eq("bp_hold2", out_code, 32'h003100B3);
    check_eq("bp_blocked", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check_eq("bp_pp_rdy", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    check_eq("bp_w2", out_code, 32'h007342B3);
    cyc();
    check_eq("bp_w3", out_code, 32'h0FF4E413);
    cyc();
    check_eq("bp_drained", 32'(out_valid), 32'd0);
    exp_issued += 3;
    check_eq("bp_cnt", 32'(issued_cnt), 32'(exp_issued));
    out_ready = 1'b0;

    // Reset with two words queued
    set_req(4'd3, 1'b0, 5'd1, 5'd1, 5'd1, 12'd0); in_valid = 1'b1;
    cyc(); cyc();
    in_valid = 1'b0;
    check_eq("mr_full", 32'(in_ready), 32'd0);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check_eq("mr_vld", 32'(out_valid), 32'd0);
    check_eq("mr_cnt", 32'(issued_cnt), 32'd0);
    check_eq("mr_code", out_code, 32'd0);
    check_eq("mr_rdy", 32'(in_ready), 32'd1);

    // Stream words until issued_cnt reaches 0xFFFF, then wrap with one pop
    set_req(4'd0, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    pops = 0; guard = 0;
    while (pops < 65535 && guard < 70000) begin
      if (out_valid) pops++;
      cyc();
      guard++;
    end
    check_eq("wrap_pre", 32'(issued_cnt), 32'h0000FFFF);
    check_eq("wrap_vld", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    cyc();
    check_eq("wrap_zero", 32'(issued_cnt), 32'd0);
    out_ready = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
